// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its IF/ID register.
package fetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0) placed in IF/ID whenever it holds a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10
    } fault_code_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } if_id_t;

    // Empty pipeline slot: nothing valid, PC fields cleared, decodes as a NOP.
    localparam if_id_t IF_ID_BUBBLE = '{
        valid:    1'b0,
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0000,
        instr:    NOP_INSTR
    };

    // A byte address is a legal instruction address only on a word boundary.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus: the fetch unit presents a byte address and the
// memory returns the addressed word in the same cycle.
interface instruction_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;

    modport master (
        output imem_addr,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        output imem_data
    );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Bubble has priority over load; with neither
// asserted the held instruction is kept (stall). Resets to a bubble.
module if_id_register
    import fetch_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_load,
    input  logic   i_bubble,
    input  if_id_t i_data,
    output if_id_t o_data
);

    if_id_t r_data;

    // Capture a fetched word, insert a bubble, or hold the current slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= IF_ID_BUBBLE;
        end else if (i_bubble) begin
            r_data <= IF_ID_BUBBLE;
        end else if (i_load) begin
            r_data <= i_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction-memory address,
// captures returned words into IF/ID, and handles stalls, EX redirects and
// fetch faults. A fault (misaligned redirect or fetch past the end of memory)
// parks the unit in HALT until reset.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64,
    parameter int          COUNT_W   = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    instruction_fetch_unit_if.master imem,
    input  logic                     i_stall,
    input  logic                     i_redirect_valid,
    input  logic [31:0]              i_redirect_target,
    output logic                     o_if_id_valid,
    output logic [31:0]              o_if_id_pc,
    output logic [31:0]              o_if_id_pc_plus4,
    output logic [31:0]              o_if_id_instr,
    output logic                     o_fault,
    output logic [1:0]               o_fault_code,
    output logic [COUNT_W-1:0]       o_fetch_count
);

    // One past the last legal byte address; 33 bits so large depths cannot overflow.
    localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) << 2;
    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    fetch_state_t       r_state;
    logic [31:0]        r_pc;
    logic               r_fault;
    fault_code_t        r_fault_code;
    logic [COUNT_W-1:0] r_fetch_count;

    logic        w_pc_in_range;
    logic        w_target_aligned;
    logic [31:0] w_pc_plus4;
    logic        w_if_id_load;
    logic        w_if_id_bubble;
    if_id_t      w_fetch_word;
    if_id_t      w_if_id;

    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_pc_in_range    = ({1'b0, r_pc} < PC_LIMIT);
    assign w_target_aligned = is_word_aligned(i_redirect_target);
    assign w_fetch_word     = '{
        valid:    1'b1,
        pc:       r_pc,
        pc_plus4: w_pc_plus4,
        instr:    imem.imem_data
    };

    // IF/ID control: redirect > stall > fetch in RUN; HALT keeps a bubble.
    always_comb begin
        w_if_id_load   = 1'b0;
        w_if_id_bubble = 1'b0;
        if (r_state == RUN) begin
            if (i_redirect_valid) begin
                w_if_id_bubble = 1'b1;
            end else if (i_stall) begin
                w_if_id_load   = 1'b0;
            end else if (w_pc_in_range) begin
                w_if_id_load   = 1'b1;
            end else begin
                w_if_id_bubble = 1'b1;
            end
        end else begin
            w_if_id_bubble = 1'b1;
        end
    end

    // Fetch FSM: PC sequencing, fault capture and the retired-fetch counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_fault       <= 1'b0;
            r_fault_code  <= FLT_NONE;
            r_fetch_count <= {COUNT_W{1'b0}};
        end else begin
            case (r_state)
                RUN: begin
                    if (i_redirect_valid) begin
                        if (w_target_aligned) begin
                            r_pc <= i_redirect_target;
                        end else begin
                            r_state      <= HALT;
                            r_fault      <= 1'b1;
                            r_fault_code <= FLT_MISALIGN;
                        end
                    end else if (i_stall) begin
                        r_pc <= r_pc;
                    end else if (w_pc_in_range) begin
                        r_pc          <= w_pc_plus4;
                        r_fetch_count <= r_fetch_count + COUNT_ONE;
                    end else begin
                        r_state      <= HALT;
                        r_fault      <= 1'b1;
                        r_fault_code <= FLT_RANGE;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    // Unreachable encoding: treat as a fault and stop fetching.
                    r_state <= HALT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    if_id_register u_if_id (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_if_id_load),
        .i_bubble (w_if_id_bubble),
        .i_data   (w_fetch_word),
        .o_data   (w_if_id)
    );

    assign imem.imem_addr   = r_pc;
    assign o_if_id_valid    = w_if_id.valid;
    assign o_if_id_pc       = w_if_id.pc;
    assign o_if_id_pc_plus4 = w_if_id.pc_plus4;
    assign o_if_id_instr    = w_if_id.instr;
    assign o_fault          = r_fault;
    assign o_fault_code     = r_fault_code;
    assign o_fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. Two instances: A (64-word
// memory) takes the directed stall/redirect/fault sequence, B (4-word memory)
// free-runs into the end-of-memory fault. Every cycle a behavioural model
// pushes the expected outputs to a scoreboard queue, which is popped and
// compared after the clock edge.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        halted;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] instr;
        logic        fault;
        logic [1:0]  code;
        logic [15:0] cnt;
    } mstate_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, stall_a, rv_a, rst_b, stall_b, rv_b;
    logic [31:0] rt_a, rt_b;
    logic [31:0] mem [64];

    logic        v_a, v_b, f_a, f_b;
    logic [31:0] pc_a, pc_b, pc4_a, pc4_b, in_a, in_b;
    logic [1:0]  fc_a, fc_b;
    logic [15:0] cnt_a, cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    mstate_t ma, mb;
    mstate_t qa[$];
    mstate_t qb[$];

    instruction_fetch_unit_if bus_a ();
    instruction_fetch_unit_if bus_b ();

    assign bus_a.imem_data = mem[bus_a.imem_addr[7:2]];
    assign bus_b.imem_data = mem[bus_b.imem_addr[7:2]];

    instruction_fetch_unit #(.MEM_WORDS(64)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .imem(bus_a.master),
        .i_stall(stall_a), .i_redirect_valid(rv_a), .i_redirect_target(rt_a),
        .o_if_id_valid(v_a), .o_if_id_pc(pc_a), .o_if_id_pc_plus4(pc4_a),
        .o_if_id_instr(in_a), .o_fault(f_a), .o_fault_code(fc_a),
        .o_fetch_count(cnt_a)
    );

    instruction_fetch_unit #(.MEM_WORDS(4)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .imem(bus_b.master),
        .i_stall(stall_b), .i_redirect_valid(rv_b), .i_redirect_target(rt_b),
        .o_if_id_valid(v_b), .o_if_id_pc(pc_b), .o_if_id_pc_plus4(pc4_b),
        .o_if_id_instr(in_b), .o_fault(f_b), .o_fault_code(fc_b),
        .o_fetch_count(cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic mstate_t bubble(input mstate_t s);
        mstate_t n = s;
        n.valid = 1'b0;
        n.ipc   = 32'h0;
        n.ipc4  = 32'h0;
        n.instr = NOP;
        return n;
    endfunction

    // Behavioural next-state model of the fetch unit.
    function automatic mstate_t model_next(input mstate_t s, input logic rst, input logic st,
                                           input logic rv, input logic [31:0] rt, input int words);
        mstate_t n = s;
        if (rst) begin
            n = bubble(n);
            n.halted = 1'b0; n.pc = 32'h0; n.fault = 1'b0; n.code = 2'b00; n.cnt = 16'h0;
        end else if (s.halted) begin
            n = bubble(n);
        end else if (rv) begin
            n = bubble(n);
            if (rt[1:0] == 2'b00) begin
                n.pc = rt;
            end else begin
                n.halted = 1'b1; n.fault = 1'b1; n.code = 2'b01;
            end
        end else if (st) begin
            n = s;
        end else if ({1'b0, s.pc} < (33'(words) * 33'd4)) begin
            n.valid = 1'b1;
            n.ipc   = s.pc;
            n.ipc4  = s.pc + 32'd4;
            n.instr = mem[s.pc[7:2]];
            n.pc    = s.pc + 32'd4;
            n.cnt   = s.cnt + 16'd1;
        end else begin
            n = bubble(n);
            n.halted = 1'b1; n.fault = 1'b1; n.code = 2'b10;
        end
        return n;
    endfunction

    task automatic compare_outputs(input string who, input mstate_t e, input logic [31:0] addr,
                                   input logic v, input logic [31:0] ipc, input logic [31:0] ipc4,
                                   input logic [31:0] instr, input logic f, input logic [1:0] fc,
                                   input logic [15:0] cnt);
        check_eq({who, ".imem_addr"}, addr, e.pc);
        check_eq({who, ".valid"}, 32'(v), 32'(e.valid));
        check_eq({who, ".if_id_pc"}, ipc, e.ipc);
        check_eq({who, ".if_id_pc_plus4"}, ipc4, e.ipc4);
        check_eq({who, ".if_id_instr"}, instr, e.instr);
        check_eq({who, ".fault"}, 32'(f), 32'(e.fault));
        check_eq({who, ".fault_code"}, 32'(fc), 32'(e.code));
        check_eq({who, ".fetch_count"}, 32'(cnt), 32'(e.cnt));
    endtask

    // Drive one cycle on A (B only ever gets reset or free-runs), score both.
    task automatic step(input logic ra, input logic st, input logic rv,
                        input logic [31:0] rt, input logic rb);
        mstate_t ea, eb;
        @(negedge clk);
        rst_a = ra; stall_a = st; rv_a = rv; rt_a = rt; rst_b = rb;
        qa.push_back(model_next(ma, ra, st, rv, rt, 64));
        qb.push_back(model_next(mb, rb, 1'b0, 1'b0, 32'h0, 4));
        ma = qa[$];
        mb = qb[$];
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        compare_outputs("A", ea, bus_a.imem_addr, v_a, pc_a, pc4_a, in_a, f_a, fc_a, cnt_a);
        compare_outputs("B", eb, bus_b.imem_addr, v_b, pc_b, pc4_b, in_b, f_b, fc_b, cnt_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h0030_0193;
        mem[2] = 32'h0031_00b3;
        mem[3] = 32'h4031_0133;
        mem[4] = 32'h0020_8093;
        mem[5] = 32'hfe31_1ae3;
        for (int i = 6; i < 64; i++) mem[i] = {16'hC0DE, 16'(i)};
        rst_a = 1'b1; stall_a = 1'b0; rv_a = 1'b0; rt_a = 32'h0;
        rst_b = 1'b1; stall_b = 1'b0; rv_b = 1'b0; rt_b = 32'h0;
        ma = '{default: '0};
        mb = '{default: '0};

        // Reset, then three free-running fetches.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("reset.valid", 32'(v_a), 32'h0);
        check_eq("reset.instr", in_a, NOP);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("run1.instr", in_a, 32'h0050_0113);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("run2.pc", pc_a, 32'h4);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("run3.pc", pc_a, 32'h8);
        check_eq("run3.pc4", pc4_a, 32'hC);
        check_eq("run3.instr", in_a, 32'h0031_00b3);
        check_eq("run3.count", 32'(cnt_a), 32'd3);

        // Two stall cycles, then release.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check_eq("stall.addr", bus_a.imem_addr, 32'hC);
        check_eq("stall.pc", pc_a, 32'h8);
        check_eq("stall.count", 32'(cnt_a), 32'd3);
        // B (4 words) has by now fetched pc 0..0xC and faulted at 0x10.
        check_eq("B.halt.code", 32'(fc_b), 32'h2);
        check_eq("B.halt.count", 32'(cnt_b), 32'd4);
        check_eq("B.halt.addr", bus_b.imem_addr, 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("release.instr", in_a, 32'h4031_0133);

        // Fetch 0x10 and 0x14 (bne), then redirect to 0x08.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("bne.pc", pc_a, 32'h14);
        step(1'b0, 1'b0, 1'b1, 32'h8, 1'b0);
        check_eq("redir.valid", 32'(v_a), 32'h0);
        check_eq("redir.addr", bus_a.imem_addr, 32'h8);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("redir.next", in_a, 32'h0031_00b3);

        // Redirect beats stall.
        step(1'b0, 1'b1, 1'b1, 32'h10, 1'b0);
        check_eq("redir_stall.addr", bus_a.imem_addr, 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Misaligned target halts; later redirects/stalls are ignored.
        step(1'b0, 1'b0, 1'b1, 32'h6, 1'b0);
        check_eq("misalign.code", 32'(fc_a), 32'h1);
        step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("halt.addr", bus_a.imem_addr, 32'h14);

        // Reset while a redirect is presented, then resume from 0.
        step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
        check_eq("rst_halt.fault", 32'(f_a), 32'h0);
        check_eq("rst_halt.addr", bus_a.imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset B out of HALT and let it run into the range fault again.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory interface in the pipelined core.
- Owns the program counter and drives the word address into the combinational instruction memory. Captures the returned word into the IF/ID pipeline register.
- Handles hazard-unit stalls, EX-stage redirects (taken branch/jump) and fetch faults.
- Stops fetching on a misaligned redirect target or a fetch beyond the end of memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MEM_WORDS, 64, instruction memory depth in words; legal fetch range is 0 .. MEM_WORDS*4-4.
- COUNT_W, 16, width of the retired-fetch counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address presented to instruction memory (equals PC register).
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect_valid  in  1  EX stage: taken branch/jump this cycle.
- redirect_target  in  32  byte address of the redirect target.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of the held instruction.
- if_id_pc_plus4  out  32  if_id_pc + 4.
- if_id_instr  out  32  held instruction word; NOP when not valid.
- fault  out  1  sticky: fetch halted.
- fault_code  out  2  00 none, 01 misaligned target, 10 out of range.
- fetch_count  out  COUNT_W  number of valid instructions captured since reset.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=RUN, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0, if_id_instr=32'h00000013 (NOP), fault=0, fault_code=00, fetch_count=0. Reset overrides every other input, including mid-redirect or while in HALT.
- imem_addr = pc, combinational from the register. Memory latency is zero, so the instruction for pc is captured at the next edge (one-cycle fetch latency to IF/ID).
- State RUN, per-edge priority is redirect > stall > normal:
  - Redirect with redirect_target[1:0]==0: pc<=redirect_target; IF/ID is loaded with a bubble (valid=0, instr=NOP, pc fields=0). Redirect wins even when stall=1.
  - Redirect with redirect_target[1:0]!=0: go to HALT; fault<=1, fault_code<=01; pc unchanged; IF/ID loaded with a bubble.
  - Stall (no redirect): pc and all IF/ID outputs hold; fetch_count holds.
  - Normal fetch, pc < MEM_WORDS*4: IF/ID<={1, pc, pc+4, imem_data}; pc<=pc+4; fetch_count<=fetch_count+1.
  - Normal fetch, pc >= MEM_WORDS*4: go to HALT; fault<=1, fault_code<=10; IF/ID loaded with a bubble; the word is not captured.
- State HALT: pc, fault and fault_code hold; IF/ID stays a bubble; redirect and stall are ignored. Exit only via rst.
- Arithmetic: pc+4 is 32-bit modulo (32'hFFFF_FFFC+4 = 0; the range check fires first for any practical MEM_WORDS). fetch_count wraps modulo 2^COUNT_W.
- pc[1:0] is always 00. The memory indexes with imem_addr[31:2].

Decomposition:
- fetch_pkg holds:
  - NOP_INSTR = 32'h00000013
  - fetch_state_t enum {RUN, HALT}
  - fault_code_t enum {FLT_NONE=2'b00, FLT_MISALIGN=2'b01, FLT_RANGE=2'b10}
  - the if_id_t struct {valid, pc, pc_plus4, instr}
- One natural sub-module, if_id_register: holds if_id_t with load/hold/bubble controls and resets to a bubble. PC, next-PC selection and the FSM stay in the top.

Test Plan:
- Reset then 3 free-running cycles with the standard program loaded:
  - IF/ID shows (pc 0, 0x00500113), then (pc 4, 0x00300193), then (pc 8, 0x003100b3).
  - if_id_pc_plus4 tracks pc+4; fetch_count=3.
- stall=1 for 2 cycles while IF/ID holds pc 8: imem_addr stays 0x0C; IF/ID unchanged; fetch_count unchanged. Release: next capture is (pc 0x0C, 0x40310133).
- redirect_valid=1, target=0x08 while IF/ID holds pc 0x14 (bne): next cycle if_id_valid=0, instr=NOP, imem_addr=0x08; following cycle (pc 8, 0x003100b3).
- redirect and stall asserted together, target=0x10: the redirect is taken (imem_addr=0x10, bubble), not the stall.
- redirect target=0x06: fault=1, fault_code=01, bubble. Later redirects and stalls have no effect. rst=1 returns pc to 0 with fault cleared.
- MEM_WORDS=4, free run from reset: four valid fetches; at pc=0x10 the unit halts with fault_code=10, if_id_valid=0 and fetch_count=4.
